// File: rtl/pn_sched_if.sv
// pn_sched_if -- signal bundle for the pn_sched job scheduler.
//   req_*   : two requesters streaming tokens into the scheduler (valid/ready)
//   pn_*    : token stream to, and result stream from, the shared PN evaluator
//   resp_*  : response beats back to the requesters (no backpressure)
//   busy    : scheduler is not idle
// The slave modport is the scheduler's view; master is the environment's view.
interface pn_sched_if;
  logic [1:0]         req_valid;
  logic [1:0]         req_last;
  logic [3:0]         req_mode;
  logic [1:0]         req_operator;
  logic [5:0]         req_in;
  logic [1:0]         req_ready;
  logic               pn_in_valid;
  logic [1:0]         pn_mode;
  logic               pn_operator;
  logic [2:0]         pn_in;
  logic               pn_out_valid;
  logic signed [31:0] pn_out;
  logic               resp_valid;
  logic               resp_id;
  logic signed [31:0] resp_data;
  logic               resp_last;
  logic               resp_err;
  logic               busy;

  modport slave (
    input  req_valid, req_last, req_mode, req_operator, req_in,
    input  pn_out_valid, pn_out,
    output req_ready,
    output pn_in_valid, pn_mode, pn_operator, pn_in,
    output resp_valid, resp_id, resp_data, resp_last, resp_err,
    output busy
  );

  modport master (
    output req_valid, req_last, req_mode, req_operator, req_in,
    output pn_out_valid, pn_out,
    input  req_ready,
    input  pn_in_valid, pn_mode, pn_operator, pn_in,
    input  resp_valid, resp_id, resp_data, resp_last, resp_err,
    input  busy
  );
endinterface

// File: rtl/pn_sched.sv
// pn_sched -- arbitrates two requesters onto one shared PN evaluator.
// A granted requester streams a job (up to MAX_TOK tokens) into a local
// buffer; the job is then replayed to the evaluator as a contiguous burst,
// and the evaluator's result beats are forwarded back one cycle later.
// Short (<3 tokens), overflowing (>MAX_TOK) or unanswered (TIMEOUT) jobs
// receive a single error beat instead.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active high
//   bus  : pn_sched_if.slave (requester, evaluator and response signals)
module pn_sched #(
  parameter int unsigned MAX_TOK = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     rst,
  pn_sched_if.slave bus
);

  localparam int unsigned NW = $clog2(MAX_TOK + 1);
  localparam int unsigned IW = $clog2(MAX_TOK);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [NW-1:0] MAX_N   = NW'(MAX_TOK);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    RESP,
    ERR
  } state_t;

  state_t        state;
  logic          g;
  logic          ptr;
  logic [1:0]    mode_q;
  logic [NW-1:0] n;
  logic [NW-1:0] idx;
  logic          ovf;
  logic [TW-1:0] wcnt;
  logic          resp_last_q;
  logic [3:0]    tok_buf [MAX_TOK];

  // Selected requester's lanes
  logic          acc_valid;
  logic          acc_last;
  logic          acc_op;
  logic [1:0]    acc_mode;
  logic [2:0]    acc_tok;
  logic          grant;
  logic          ovf_now;

  assign acc_valid = g ? bus.req_valid[1]    : bus.req_valid[0];
  assign acc_last  = g ? bus.req_last[1]     : bus.req_last[0];
  assign acc_op    = g ? bus.req_operator[1] : bus.req_operator[0];
  assign acc_mode  = g ? bus.req_mode[3:2]   : bus.req_mode[1:0];
  assign acc_tok   = g ? bus.req_in[5:3]     : bus.req_in[2:0];

  // Contention goes to the round-robin pointer, otherwise to whoever asks.
  assign grant   = (bus.req_valid == 2'b11) ? ptr : bus.req_valid[1];
  assign ovf_now = ovf | (n == MAX_N);

  assign bus.busy = (state != IDLE);

  // resp_last depends on whether the evaluator is still streaming in the
  // same cycle the forwarded beat is presented, so it cannot be registered.
  assign bus.resp_last = resp_last_q | ((state == RESP) & ~bus.pn_out_valid);

  // Token storage is not reset; its contents only matter once loaded.
  always_ff @(posedge clk) begin
    if (state == LOAD && acc_valid && n != MAX_N) begin
      tok_buf[n[IW-1:0]] <= {acc_op, acc_tok};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      g               <= 1'b0;
      ptr             <= 1'b0;
      mode_q          <= '0;
      n               <= '0;
      idx             <= '0;
      ovf             <= 1'b0;
      wcnt            <= '0;
      resp_last_q     <= 1'b0;
      bus.req_ready   <= '0;
      bus.pn_in_valid <= 1'b0;
      bus.pn_mode     <= '0;
      bus.pn_operator <= 1'b0;
      bus.pn_in       <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= 1'b0;
      bus.resp_data   <= '0;
      bus.resp_err    <= 1'b0;
    end else begin
      bus.pn_in_valid <= 1'b0;
      bus.pn_mode     <= '0;
      bus.pn_operator <= 1'b0;
      bus.pn_in       <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= 1'b0;
      bus.resp_data   <= '0;
      bus.resp_err    <= 1'b0;
      resp_last_q     <= 1'b0;

      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            g             <= grant;
            bus.req_ready <= grant ? 2'b10 : 2'b01;
            n             <= '0;
            ovf           <= 1'b0;
            state         <= LOAD;
          end
        end

        LOAD: begin
          if (acc_valid) begin
            if (n == '0) begin
              mode_q <= acc_mode;
            end
            if (n != MAX_N) begin
              n <= n + 1'b1;
            end else begin
              ovf <= 1'b1;
            end
            if (acc_last) begin
              bus.req_ready <= '0;
              if (ovf_now || n < NW'(2)) begin
                state          <= ERR;
                bus.resp_valid <= 1'b1;
                bus.resp_err   <= 1'b1;
                bus.resp_id    <= g;
                resp_last_q    <= 1'b1;
                ptr            <= ~g;
              end else begin
                // Token 0 goes out on the entry edge so the burst lines up
                // exactly with the ISSUE state.
                state           <= ISSUE;
                bus.pn_in_valid <= 1'b1;
                bus.pn_mode     <= mode_q;
                bus.pn_operator <= tok_buf[0][3];
                bus.pn_in       <= tok_buf[0][2:0];
                idx             <= NW'(1);
              end
            end
          end
        end

        ISSUE: begin
          if (idx == n) begin
            state <= WAIT;
            wcnt  <= '0;
          end else begin
            bus.pn_in_valid <= 1'b1;
            bus.pn_mode     <= mode_q;
            bus.pn_operator <= tok_buf[idx[IW-1:0]][3];
            bus.pn_in       <= tok_buf[idx[IW-1:0]][2:0];
            idx             <= idx + 1'b1;
          end
        end

        // The error beat appears exactly TIMEOUT cycles after WAIT is entered.
        WAIT: begin
          if (bus.pn_out_valid) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= bus.pn_out;
            bus.resp_id    <= g;
          end else if (wcnt == T_LAST) begin
            state          <= ERR;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_id    <= g;
            resp_last_q    <= 1'b1;
            ptr            <= ~g;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        RESP: begin
          if (bus.pn_out_valid) begin
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= bus.pn_out;
            bus.resp_id    <= g;
          end else begin
            state <= IDLE;
            ptr   <= ~g;
          end
        end

        ERR: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pn_sched.sv
module tb_pn_sched;
  localparam int unsigned MAX_TOK = 12;
  localparam int unsigned TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pn_sched_if bus ();

  pn_sched #(.MAX_TOK(MAX_TOK), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int viol     = 0;
  bit ptr_m    = 1'b0;

  logic [3:0]  tok_q[$];
  logic [31:0] reply_q[$];

  logic [3:0]  iss_tok[$];
  logic [1:0]  iss_mode[$];
  int          iss_cyc[$];
  logic [31:0] rsp_data[$];
  logic        rsp_id[$];
  logic        rsp_last[$];
  logic        rsp_err[$];
  int          rsp_cyc[$];
  int          ev_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observation of DUT outputs, away from the active edge.
  always @(negedge clk) begin
    if (bus.pn_in_valid) begin
      iss_tok.push_back({bus.pn_operator, bus.pn_in});
      iss_mode.push_back(bus.pn_mode);
      iss_cyc.push_back(cyc);
    end else if (bus.pn_mode != 2'b0 || bus.pn_operator || bus.pn_in != 3'b0) begin
      viol++;
    end
    if (bus.resp_valid) begin
      rsp_data.push_back(bus.resp_data);
      rsp_id.push_back(bus.resp_id);
      rsp_last.push_back(bus.resp_last);
      rsp_err.push_back(bus.resp_err);
      rsp_cyc.push_back(cyc);
    end else if (bus.resp_data != 32'b0 || bus.resp_id || bus.resp_last || bus.resp_err) begin
      viol++;
    end
    if (bus.pn_out_valid) ev_cyc.push_back(cyc);
    if (bus.req_ready == 2'b11) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    iss_tok.delete(); iss_mode.delete(); iss_cyc.delete();
    rsp_data.delete(); rsp_id.delete(); rsp_last.delete(); rsp_err.delete();
    rsp_cyc.delete(); ev_cyc.delete();
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0; bus.req_last = '0; bus.req_mode = '0;
    bus.req_operator = '0; bus.req_in = '0;
    bus.pn_out_valid = 1'b0; bus.pn_out = '0;
  endtask

  task automatic fill_tokens(input int n);
    tok_q.delete();
    repeat (n) tok_q.push_back(4'($urandom));
  endtask

  task automatic fill_replies(input int k);
    reply_q.delete();
    repeat (k) reply_q.push_back($urandom);
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    ptr_m = 1'b0;
  endtask

  // One job: expected grant, issue burst and response are derived from the
  // job description (token list, reply list) and the bench's own pointer.
  task automatic do_job(input int r_in, input bit contend, input int gap, input logic [1:0] mode);
    int r, n, c_wait, other_bad;
    bit err, ok, issued, done;
    logic [1:0] rdy_seen;
    r = contend ? int'(ptr_m) : r_in;
    n = tok_q.size();
    err = (n > int'(MAX_TOK)) || (n < 3);
    clear_obs();
    rdy_seen = '0;
    other_bad = 0;
    c_wait = 0;
    bus.req_valid = contend ? 2'b11 : 2'b00;
    bus.req_last = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          bus.req_valid[r] = 1'b0;
          bus.req_in[3*r +: 3] = 3'($urandom);
          tick();
        end
      end
      bus.req_valid[r] = 1'b1;
      bus.req_in[3*r +: 3] = tok_q[i][2:0];
      bus.req_operator[r] = tok_q[i][3];
      bus.req_last[r] = (i == n - 1);
      bus.req_mode[2*r +: 2] = (i == 0) ? mode : 2'($urandom);
      ok = 1'b0;
      for (int w = 0; w < 20 && !ok; w++) begin
        @(negedge clk);
        if (rdy_seen == 2'b00) rdy_seen = bus.req_ready;
        if (bus.req_ready[1-r]) other_bad++;
        ok = bus.req_ready[r];
        tick();
      end
      chk("token_accepted", 32'(ok), 32'd1);
      if (!ok) break;
    end
    idle_inputs();
    chk("grant", 32'(rdy_seen), 32'(2'b01 << r));
    chk("other_ready_low", 32'(other_bad), 32'd0);

    if (!err) begin
      issued = 1'b0;
      for (int w = 0; w < n + 20 && !issued; w++) begin
        @(negedge clk);
        if (iss_tok.size() == n && !bus.pn_in_valid) begin
          issued = 1'b1;
          c_wait = cyc;
        end
      end
      chk("issue_done", 32'(issued), 32'd1);
      foreach (reply_q[j]) begin
        tick();
        bus.pn_out_valid = 1'b1;
        bus.pn_out = reply_q[j];
      end
      tick();
      bus.pn_out_valid = 1'b0;
      bus.pn_out = '0;
    end

    done = 1'b0;
    for (int w = 0; w < int'(TIMEOUT) + 50 && !done; w++) begin
      @(negedge clk);
      done = !bus.busy;
    end
    chk("job_idle", 32'(done), 32'd1);

    if (err || reply_q.size() == 0) begin
      chk("err_issue_count", 32'(iss_tok.size()), err ? 32'd0 : 32'(n));
      chk("err_beats", 32'(rsp_data.size()), 32'd1);
      if (rsp_data.size() >= 1) begin
        chk("err_flag", 32'(rsp_err[0]), 32'd1);
        chk("err_last", 32'(rsp_last[0]), 32'd1);
        chk("err_data", rsp_data[0], 32'd0);
        chk("err_id", 32'(rsp_id[0]), 32'(r));
        if (!err) chk("timeout_cycles", 32'(rsp_cyc[0] - c_wait), 32'(TIMEOUT));
      end
    end else begin
      chk("issue_count", 32'(iss_tok.size()), 32'(n));
      if (iss_tok.size() == n) begin
        for (int i = 0; i < n; i++) begin
          chk("issue_token", 32'(iss_tok[i]), 32'(tok_q[i]));
          chk("issue_mode", 32'(iss_mode[i]), 32'(mode));
        end
        chk("issue_contiguous", 32'(iss_cyc[n-1] - iss_cyc[0]), 32'(n - 1));
      end
      chk("resp_beats", 32'(rsp_data.size()), 32'(reply_q.size()));
      if (rsp_data.size() == reply_q.size() && ev_cyc.size() == reply_q.size()) begin
        foreach (reply_q[j]) begin
          chk("resp_data", rsp_data[j], reply_q[j]);
          chk("resp_id", 32'(rsp_id[j]), 32'(r));
          chk("resp_err", 32'(rsp_err[j]), 32'd0);
          chk("resp_last", 32'(rsp_last[j]), 32'(j == reply_q.size() - 1));
          chk("resp_delay", 32'(rsp_cyc[j] - ev_cyc[j]), 32'd1);
        end
      end
    end
    ptr_m = ~r[0];
  endtask

  initial begin
    int busy_seen;
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_pn_in_valid", 32'(bus.pn_in_valid), 32'd0);
    chk("rst_pn_in", 32'(bus.pn_in), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_last", 32'(bus.resp_last), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b0;
    ptr_m = 1'b0;

    // Basic job: 3 tokens, mode 2, single reply of 7
    fill_tokens(3);
    reply_q.delete(); reply_q.push_back(32'd7);
    do_job(0, 1'b0, 0, 2'd2);

    // Contention after reset: 0, then 1, then 0
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      fill_tokens(int'($urandom_range(3, MAX_TOK)));
      fill_replies(int'($urandom_range(1, 3)));
      do_job(0, 1'b1, 0, 2'($urandom));
    end

    // Bubbled load from requester 1
    fill_tokens(6);
    fill_replies(1);
    do_job(1, 1'b0, 2, 2'd1);

    // Overflow, short job, exact-capacity job, evaluator timeout
    fill_tokens(MAX_TOK + 1); reply_q.delete();
    do_job(0, 1'b0, 0, 2'd3);
    fill_tokens(2); reply_q.delete();
    do_job(1, 1'b0, 1, 2'd0);
    fill_tokens(MAX_TOK); fill_replies(2);
    do_job(1, 1'b0, 0, 2'd2);
    fill_tokens(4); reply_q.delete();
    do_job(0, 1'b0, 0, 2'd1);

    // Multi-beat reply 9, 5, 2, -3
    fill_tokens(5);
    reply_q.delete();
    reply_q.push_back(32'd9); reply_q.push_back(32'd5);
    reply_q.push_back(32'd2); reply_q.push_back(-32'sd3);
    do_job(1, 1'b0, 0, 2'd0);

    // Random jobs, including short and overflowing ones
    for (int k = 0; k < 5; k++) begin
      fill_tokens(int'($urandom_range(1, MAX_TOK + 2)));
      fill_replies(int'($urandom_range(1, 3)));
      do_job(int'($urandom_range(0, 1)), 1'($urandom), int'($urandom_range(0, 2)), 2'($urandom));
    end

    // Reset during LOAD abandons the job silently
    clear_obs();
    bus.req_valid = 2'b01;
    bus.req_mode = 4'd3;
    repeat (4) begin
      bus.req_in[2:0] = 3'($urandom);
      tick();
    end
    @(negedge clk);
    chk("load_busy", 32'(bus.busy), 32'd1);
    tick();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    ptr_m = 1'b0;
    busy_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    chk("rst_load_busy", 32'(busy_seen), 32'd0);
    chk("rst_load_no_resp", 32'(rsp_data.size()), 32'd0);
    chk("rst_load_no_issue", 32'(iss_tok.size()), 32'd0);

    // Recovery: pointer back at 0 after reset
    fill_tokens(3); fill_replies(1);
    do_job(0, 1'b1, 0, 2'd2);

    chk("idle_outputs_zero", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pn_sched.md
PN_SCHED -- requirements
Module: pn_sched

Interface
REQ-001 Parameters SHALL be: MAX_TOK, 12, token buffer depth; TIMEOUT, 255, WAIT-state cycle limit before an error response.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  2  per-requester token valid; bit k = requester k.
- req_last  in  2  final token of requester k's job.
- req_mode  in  4  [2k+1:2k] = mode of requester k.
- req_operator  in  2  bit k = token is an operator.
- req_in  in  6  [3k+2:3k] = 3-bit token of requester k.
- req_ready  out  2  token accepted from requester k when valid and ready.
- pn_in_valid  out  1  token strobe to the shared PN evaluator.
- pn_mode  out  2  mode to the evaluator.
- pn_operator  out  1  operator flag to the evaluator.
- pn_in  out  3  token to the evaluator.
- pn_out_valid  in  1  evaluator result strobe.
- pn_out  in  32  evaluator result, signed.
- resp_valid  out  1  response beat.
- resp_id  out  1  requester that owns the response.
- resp_data  out  32  result, signed.
- resp_last  out  1  final beat of the response.
- resp_err  out  1  job rejected or timed out.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, ISSUE, WAIT, RESP and ERR.
REQ-004 In IDLE, any req_valid bit SHALL select grant g:
- Only one requester valid: grant that requester.
- Both valid: grant the round-robin pointer ptr.
- Next state: LOAD.
REQ-005 req_ready[g] SHALL be 1 only in LOAD; req_ready of the other requester SHALL be 0 always.
REQ-006 In LOAD, mode SHALL be latched from req_mode[g] with the first accepted token; later mode values are ignored.
REQ-007 Accepted tokens SHALL be stored at indices 0..MAX_TOK-1 in arrival order; count N increments per accepted token.
REQ-008 Bubbles (req_valid[g] low) during LOAD SHALL be tolerated without limit.
REQ-009 Tokens beyond MAX_TOK SHALL be accepted and discarded, and an overflow flag set.
REQ-010 On acceptance of the token with req_last[g]=1:
- Overflow set, or N<3: next state ERR.
- Otherwise: next state ISSUE.
REQ-011 In ISSUE, pn_in_valid SHALL be high for exactly N consecutive cycles, presenting tokens 0..N-1 in order, with pn_mode held at the latched mode on every cycle; next state WAIT.
REQ-012 pn_mode, pn_operator and pn_in SHALL be 0 whenever pn_in_valid is 0.
REQ-013 In WAIT, a cycle counter SHALL start at 0:
- First pn_out_valid: enter RESP.
- Counter reaching TIMEOUT: enter ERR.
REQ-014 In RESP, each pn_out_valid beat SHALL be forwarded one cycle later:
- resp_valid=1, resp_data=pn_out, resp_id=g, resp_err=0.
- resp_last=1 on the forwarded beat whose following cycle has pn_out_valid=0.
- After resp_last, return to IDLE.
REQ-015 ERR SHALL emit one beat, then return to IDLE:
- resp_valid=1, resp_last=1, resp_err=1, resp_data=0, resp_id=g.
REQ-016 ptr SHALL be set to ~g in the cycle the job's resp_last beat is emitted, for both normal and error completions.
REQ-017 pn_out_valid SHALL be ignored in IDLE, LOAD, ISSUE and ERR.
REQ-018 When resp_valid=0, resp_data, resp_id, resp_last and resp_err SHALL be 0.
REQ-019 There is no response backpressure; a response beat is presented for one cycle only.

Reset
REQ-020 While rst=1 at a clock edge:
- State returns to IDLE; ptr=0; N=0; overflow=0.
- All outputs are 0.
- Token buffer contents are don't-care.
REQ-021 Reset asserted mid-job (any state) SHALL abandon the job with no response beat.

Verification
REQ-022 Basic job: requester 0 sends 3 tokens, mode=2, last on the 3rd -> pn_in_valid high 3 consecutive cycles; the evaluator returns 7 -> one beat with resp_data=7, resp_id=0, resp_last=1.
REQ-023 Contention: both requesters valid in IDLE after reset -> requester 0 is served first, then requester 1; a third contended job goes to requester 0.
REQ-024 Bubbled load: 6 tokens from requester 1 with 2-cycle gaps -> pn_in_valid shows 6 contiguous cycles, tokens in order.
REQ-025 Errors:
- 13 tokens -> no pn_in_valid; one beat with resp_err=1, resp_data=0.
- 2 tokens -> same single error beat.
- No evaluator reply -> error beat TIMEOUT cycles after entering WAIT.
REQ-026 Multi-beat reply: mode=0 job whose evaluator returns 4 beats (9,5,2,-3) -> 4 resp beats, one cycle delayed, resp_last only on -3; reset asserted during LOAD -> busy=0 and no response.
